// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the instruction-fetch slice
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int          WORD_BYTES       = 4;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // last_pc is the highest word address that can still be fetched
  function automatic logic pc_fault(input logic [31:0] pc, input logic [31:0] last_pc);
    return (pc[1:0] != 2'b00) || (pc > last_pc);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_if.sv
// ============================================================================
// fetch_if : instruction-memory, redirect and decode-side handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fetch_fault;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  fetch_fault
  );
endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO of fetch entries; flush beats push and pop
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   push,
  input  wire logic                   pop,
  input  wire logic                   flush,
  input  wire fetch_entry_t           wr_data,
  output fetch_entry_t                head,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_q alone
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC register, fault detection and push control over fetch_fifo
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          MEM_BYTES = 64,
  parameter int          DEPTH     = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  fetch_if.master   bus
);

  localparam int               CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0]      LAST_PC  = 32'(MEM_BYTES - WORD_BYTES);

  logic [31:0]      pc_q, pc_d;
  logic             fault;
  logic             pop;
  logic             can_push;
  logic             push;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     wr_entry;

  // Fault is a pure function of pc; pc freezes while faulted, so it stays set
  assign fault    = pc_fault(pc_q, LAST_PC);
  assign pop      = bus.out_valid & bus.out_ready;
  assign can_push = !fault && ((count < FULL_CNT) || pop);
  assign push     = can_push && !bus.redirect_valid;

  assign wr_entry.pc   = pc_q;
  assign wr_entry.inst = bus.imem_inst;

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (push) begin
      pc_d = pc_q + 32'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (bus.redirect_valid),
    .wr_data (wr_entry),
    .head    (head),
    .count   (count)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.out_valid   = (count != '0);
  assign bus.out_inst    = head.inst;
  assign bus.out_pc      = head.pc;
  assign bus.fetch_fault = fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed and randomized checks of fetch_unit against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int          MEM_BYTES = 64;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_if bus();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES),
    .DEPTH     (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: return 32'h0000B037;
      32'h04: return 32'hBCD00013;
      32'h08: return 32'h0000A023;
      32'h20: return 32'h06108013;
      32'h24: return 32'h000A1623;
      default: return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign bus.imem_inst = mem_word(bus.imem_addr);

  // Reference: ordered list of {pc, inst} still owed to decode, plus the fetch pc
  logic [63:0] mq[$];
  logic [31:0] mpc;

  function automatic bit m_fault(input logic [31:0] p);
    return (p % 4 != 0) || ({32'b0, p} + 64'd4 > 64'(MEM_BYTES));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mpc = RESET_PC;
    end else begin
      bit m_pop;
      bit m_room;
      m_pop = (mq.size() > 0) && bus.out_ready;
      if (bus.redirect_valid) begin
        mq.delete();
        mpc = bus.redirect_pc;
      end else begin
        m_room = !m_fault(mpc) && ((mq.size() < DEPTH) || m_pop);
        if (m_pop) void'(mq.pop_front());
        if (m_room) begin
          mq.push_back({mpc, mem_word(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model imem_addr", bus.imem_addr, mpc);
    chk("model out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("model fetch_fault", 32'(bus.fetch_fault), 32'(m_fault(mpc)));
    if (mq.size() != 0) begin
      chk("model out_pc", bus.out_pc, mq[0][63:32]);
      chk("model out_inst", bus.out_inst, mq[0][31:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst_n              = 1'b0;
    step();
    step();
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_pc", bus.out_pc, 32'h0);
    chk("reset out_inst", bus.out_inst, 32'h0);
    chk("reset fault", 32'(bus.fetch_fault), 32'd0);
    chk("reset imem_addr", bus.imem_addr, RESET_PC);

    // Sequential stream from reset
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("t1 pc0", bus.out_pc, 32'h0);
    chk("t1 inst0", bus.out_inst, 32'h0000B037);
    chk("t1 addr", bus.imem_addr, 32'h4);
    step();
    chk("t1 pc4", bus.out_pc, 32'h4);
    chk("t1 inst4", bus.out_inst, 32'hBCD00013);
    chk("t1 addr2", bus.imem_addr, 32'h8);
    step();
    chk("t1 pc8", bus.out_pc, 32'h8);
    chk("t1 inst8", bus.out_inst, 32'h0000A023);

    // Backpressure fills the buffer, then drains without gaps
    do_reset();
    bus.out_ready = 1'b0;
    repeat (5) step();
    chk("t2 addr held", bus.imem_addr, 32'h8);
    chk("t2 inst held", bus.out_inst, 32'h0000B037);
    chk("t2 pc held", bus.out_pc, 32'h0);
    chk("t2 valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("t2 drain4", bus.out_pc, 32'h4);
    step();
    chk("t2 drain8", bus.out_pc, 32'h8);
    step();
    chk("t2 drainC", bus.out_pc, 32'hC);

    // Redirect flushes the stale 0x10 entry
    redirect(32'h20);
    chk("t3 bubble", 32'(bus.out_valid), 32'd0);
    chk("t3 addr", bus.imem_addr, 32'h20);
    step();
    chk("t3 pc20", bus.out_pc, 32'h20);
    chk("t3 inst20", bus.out_inst, 32'h06108013);
    step();
    chk("t3 pc24", bus.out_pc, 32'h24);
    chk("t3 inst24", bus.out_inst, 32'h000A1623);

    // Misaligned redirect faults and halts; a good redirect recovers
    redirect(32'h22);
    chk("t4 fault", 32'(bus.fetch_fault), 32'd1);
    chk("t4 empty", 32'(bus.out_valid), 32'd0);
    repeat (3) step();
    chk("t4 pc hold", bus.imem_addr, 32'h22);
    chk("t4 still empty", 32'(bus.out_valid), 32'd0);
    chk("t4 sticky", 32'(bus.fetch_fault), 32'd1);
    redirect(32'h30);
    chk("t4 cleared", 32'(bus.fetch_fault), 32'd0);
    step();
    chk("t4 pc30", bus.out_pc, 32'h30);

    // Running off the end of memory
    redirect(32'h34);
    step();
    chk("t5 pc34", bus.out_pc, 32'h34);
    step();
    chk("t5 pc38", bus.out_pc, 32'h38);
    step();
    chk("t5 pc3C", bus.out_pc, 32'h3C);
    chk("t5 fault", 32'(bus.fetch_fault), 32'd1);
    chk("t5 addr40", bus.imem_addr, 32'h40);
    step();
    chk("t5 drained", 32'(bus.out_valid), 32'd0);
    chk("t5 fault held", 32'(bus.fetch_fault), 32'd1);

    // Asynchronous reset with a full buffer
    redirect(32'h0);
    bus.out_ready = 1'b0;
    step();
    step();
    chk("t6 buffered", 32'(bus.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 async valid", 32'(bus.out_valid), 32'd0);
    chk("t6 async pc", bus.out_pc, 32'h0);
    chk("t6 async inst", bus.out_inst, 32'h0);
    chk("t6 async addr", bus.imem_addr, RESET_PC);
    chk("t6 async fault", 32'(bus.fetch_fault), 32'd0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    chk("t6 first pc", bus.out_pc, RESET_PC);
    chk("t6 first valid", 32'(bus.out_valid), 32'd1);

    // Randomized traffic against the model
    repeat (3000) begin
      bus.out_ready      = ($urandom_range(0, 99) < 70);
      bus.redirect_valid = ($urandom_range(0, 15) == 0);
      if (bus.redirect_valid) begin
        case ($urandom_range(0, 7))
          0:       bus.redirect_pc = $urandom;
          1:       bus.redirect_pc = 32'($urandom_range(0, 31) * 4);
          2:       bus.redirect_pc = 32'h38 + 32'($urandom_range(0, 1) * 4);
          3:       bus.redirect_pc = 32'($urandom_range(0, 63));
          default: bus.redirect_pc = 32'($urandom_range(0, 15) * 4);
        endcase
      end
      if ($urandom_range(0, 299) == 0) begin
        bus.redirect_valid = 1'b0;
        do_reset();
      end else begin
        step();
      end
    end
    bus.redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
